// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit nibble writer.
// States, opcodes, 50 MHz default timing, counter width.
package lcd_pkg;

    localparam int CNT_W = 20;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HI_SETUP,
        ST_HI_PULSE,
        ST_HI_HOLD,
        ST_GAP,
        ST_LO_SETUP,
        ST_LO_PULSE,
        ST_LO_HOLD,
        ST_WAIT
    } lcdState_t;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
    localparam logic [7:0] LCD_CMD_HOME2 = 8'h03;

    localparam int DEF_SETUP_CYCLES      = 2;
    localparam int DEF_ENABLE_CYCLES     = 12;
    localparam int DEF_HOLD_CYCLES       = 2;
    localparam int DEF_NIBBLE_GAP_CYCLES = 50;
    localparam int DEF_CMD_WAIT_CYCLES   = 2000;
    localparam int DEF_CLEAR_WAIT_CYCLES = 82000;

    // Clear and return-home need the long execution wait.
    // 8'h03 decodes as return-home on HD44780 parts.
    function automatic logic needsLongWait(
        input logic [7:0] data,
        input logic       rs
    );
        return !rs && (data == LCD_CMD_CLEAR ||
                       data == LCD_CMD_HOME  ||
                       data == LCD_CMD_HOME2);
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter timing each LCD phase.
// Ports: Clock, Reset(n), iLoad, iValue -> oZero.
module lcd_delay_counter
    import lcd_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         iLoad,
    input  logic [W-1:0] iValue,
    output logic         oZero
);

    logic [W-1:0] count;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (iLoad) begin
            count <= iValue;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign oZero = (count == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// Drives an HD44780 LCD in 4-bit mode, one byte per request.
// Ports: Clock, Reset(n), iData, iRS, iValid -> oReady, oDone, oLCD_*.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYCLES      = DEF_SETUP_CYCLES,
    parameter int ENABLE_CYCLES     = DEF_ENABLE_CYCLES,
    parameter int HOLD_CYCLES       = DEF_HOLD_CYCLES,
    parameter int NIBBLE_GAP_CYCLES = DEF_NIBBLE_GAP_CYCLES,
    parameter int CMD_WAIT_CYCLES   = DEF_CMD_WAIT_CYCLES,
    parameter int CLEAR_WAIT_CYCLES = DEF_CLEAR_WAIT_CYCLES
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic       oDone,
    output logic [3:0] oLCD_D,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW
);

    // Counter reload values: N-1 so each state lasts N cycles.
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ENABLE_LD = CNT_W'(ENABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(NIBBLE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMD_LD    = CNT_W'(CMD_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD  = CNT_W'(CLEAR_WAIT_CYCLES - 1);

    lcdState_t        state;
    lcdState_t        stateNext;
    logic             cntLoad;
    logic [CNT_W-1:0] cntValue;
    logic             cntZero;
    logic [7:0]       dataQ;
    logic             rsQ;
    logic             longQ;
    logic             accept;

    assign accept = iValid && oReady;

    lcd_delay_counter #(
        .W(CNT_W)
    ) uDelay (
        .Clock (Clock),
        .Reset (Reset),
        .iLoad (cntLoad),
        .iValue(cntValue),
        .oZero (cntZero)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            dataQ <= '0;
            rsQ   <= 1'b0;
            longQ <= 1'b0;
        end else if (accept) begin
            dataQ <= iData;
            rsQ   <= iRS;
            longQ <= needsLongWait(iData, iRS);
        end
    end

    always_comb begin
        stateNext = state;
        cntLoad   = 1'b0;
        cntValue  = '0;
        unique case (state)
            ST_IDLE: begin
                if (iValid) begin
                    stateNext = ST_HI_SETUP;
                    cntLoad   = 1'b1;
                    cntValue  = SETUP_LD;
                end
            end
            ST_HI_SETUP: begin
                if (cntZero) begin
                    stateNext = ST_HI_PULSE;
                    cntLoad   = 1'b1;
                    cntValue  = ENABLE_LD;
                end
            end
            ST_HI_PULSE: begin
                if (cntZero) begin
                    stateNext = ST_HI_HOLD;
                    cntLoad   = 1'b1;
                    cntValue  = HOLD_LD;
                end
            end
            ST_HI_HOLD: begin
                if (cntZero) begin
                    stateNext = ST_GAP;
                    cntLoad   = 1'b1;
                    cntValue  = GAP_LD;
                end
            end
            ST_GAP: begin
                if (cntZero) begin
                    stateNext = ST_LO_SETUP;
                    cntLoad   = 1'b1;
                    cntValue  = SETUP_LD;
                end
            end
            ST_LO_SETUP: begin
                if (cntZero) begin
                    stateNext = ST_LO_PULSE;
                    cntLoad   = 1'b1;
                    cntValue  = ENABLE_LD;
                end
            end
            ST_LO_PULSE: begin
                if (cntZero) begin
                    stateNext = ST_LO_HOLD;
                    cntLoad   = 1'b1;
                    cntValue  = HOLD_LD;
                end
            end
            ST_LO_HOLD: begin
                if (cntZero) begin
                    stateNext = ST_WAIT;
                    cntLoad   = 1'b1;
                    cntValue  = longQ ? CLEAR_LD : CMD_LD;
                end
            end
            ST_WAIT: begin
                if (cntZero) begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // All outputs decode registered state only.
    always_comb begin
        oReady  = (state == ST_IDLE);
        oDone   = (state == ST_WAIT) && cntZero;
        oLCD_E  = (state == ST_HI_PULSE) || (state == ST_LO_PULSE);
        oLCD_RS = (state == ST_IDLE) ? 1'b0 : rsQ;
        oLCD_RW = 1'b0;
        unique case (state)
            ST_IDLE:      oLCD_D = 4'h0;
            ST_HI_SETUP,
            ST_HI_PULSE,
            ST_HI_HOLD,
            ST_GAP:       oLCD_D = dataQ[7:4];
            default:      oLCD_D = dataQ[3:0];
        endcase
    end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed self-checking bench for lcd_nibble_writer.
// Checks every busy cycle of each transfer against a cycle model.
module tb_lcd_nibble_writer;

    localparam int S  = 2;
    localparam int EN = 3;
    localparam int H  = 1;
    localparam int G  = 4;
    localparam int CW = 10;
    localparam int LW = 20;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iRS = 1'b0;
    logic       iValid = 1'b0;
    logic       oReady;
    logic       oDone;
    logic [3:0] oLCD_D;
    logic       oLCD_E;
    logic       oLCD_RS;
    logic       oLCD_RW;

    int errors = 0;
    int checks = 0;

    lcd_nibble_writer #(
        .SETUP_CYCLES     (S),
        .ENABLE_CYCLES    (EN),
        .HOLD_CYCLES      (H),
        .NIBBLE_GAP_CYCLES(G),
        .CMD_WAIT_CYCLES  (CW),
        .CLEAR_WAIT_CYCLES(LW)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .iData  (iData),
        .iRS    (iRS),
        .iValid (iValid),
        .oReady (oReady),
        .oDone  (oDone),
        .oLCD_D (oLCD_D),
        .oLCD_E (oLCD_E),
        .oLCD_RS(oLCD_RS),
        .oLCD_RW(oLCD_RW)
    );

    always #5 Clock = ~Clock;

    // Observed bundle: ready, done, D[3:0], E, RS, RW.
    function automatic logic [8:0] obsVec();
        return {oReady, oDone, oLCD_D, oLCD_E, oLCD_RS, oLCD_RW};
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs,
                       input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    localparam logic [8:0] IDLE_VEC = 9'b1_0_0000_0_0_0;

    // One transfer: idle check, accept, then every busy cycle.
    task automatic xfer(input string name, input logic [7:0] d,
                        input logic rs, input int waitN,
                        input logic keepValid, input logic [7:0] nextD,
                        input logic nextRs, input logic pulseBusy);
        int b;
        int hiEnd;
        logic [3:0] expD;
        logic expE;
        b = 2 * (S + EN + H) + G + waitN;
        hiEnd = S + EN + H + G;
        @(negedge Clock);
        chk({name, " idle"}, obsVec(), IDLE_VEC);
        iData = d;
        iRS = rs;
        iValid = 1'b1;
        @(posedge Clock);
        #1;
        iValid = keepValid;
        for (int c = 1; c <= b; c++) begin
            @(negedge Clock);
            if (c == 6) begin
                iData = nextD;
                iRS = nextRs;
            end
            if (pulseBusy && c == 8) iValid = 1'b1;
            if (pulseBusy && c == 9) iValid = 1'b0;
            expD = (c <= hiEnd) ? d[7:4] : d[3:0];
            expE = (c > S && c <= S + EN) ||
                   (c > hiEnd + S && c <= hiEnd + S + EN);
            chk($sformatf("%s c%0d", name, c), obsVec(),
                {1'b0, (c == b), expD, expE, rs, 1'b0});
        end
    endtask

    initial begin
        #12;
        chk("reset", obsVec(), IDLE_VEC);
        @(negedge Clock);
        Reset = 1'b1;

        xfer("data48", 8'h48, 1'b1, CW, 1'b0, 8'hFF, 1'b0, 1'b0);
        xfer("clr01", 8'h01, 1'b0, LW, 1'b0, 8'h3C, 1'b1, 1'b0);
        xfer("cmd28", 8'h28, 1'b0, CW, 1'b0, 8'h01, 1'b0, 1'b0);
        xfer("home02", 8'h02, 1'b0, LW, 1'b0, 8'h00, 1'b0, 1'b0);
        xfer("home03", 8'h03, 1'b0, LW, 1'b0, 8'h00, 1'b0, 1'b0);
        xfer("data01", 8'h01, 1'b1, CW, 1'b0, 8'h00, 1'b0, 1'b0);

        xfer("b2b41", 8'h41, 1'b1, CW, 1'b1, 8'h42, 1'b1, 1'b0);
        xfer("b2b42", 8'h42, 1'b1, CW, 1'b0, 8'h99, 1'b0, 1'b0);

        xfer("busy5A", 8'h5A, 1'b1, CW, 1'b0, 8'h01, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            chk($sformatf("noextra%0d", k), obsVec(), IDLE_VEC);
        end

        @(negedge Clock);
        iData = 8'h48;
        iRS = 1'b1;
        iValid = 1'b1;
        @(posedge Clock);
        #1;
        iValid = 1'b0;
        repeat (3) @(negedge Clock);
        chk("rst pulse", obsVec(), {1'b0, 1'b0, 4'h4, 1'b1, 1'b1, 1'b0});
        #1;
        Reset = 1'b0;
        #1;
        chk("rst async", obsVec(), IDLE_VEC);
        @(negedge Clock);
        chk("rst held", obsVec(), IDLE_VEC);
        Reset = 1'b1;

        xfer("post rst", 8'hC3, 1'b1, CW, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge Clock);
        chk("final idle", obsVec(), IDLE_VEC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
